uart_rx_fsm: RTL and testbench
==============================

// Module: uart_rx_fsm
// PURPOSE
//  Frame sequencer for the UART receive path. Detects the start bit, runs the
//  oversampling edge counter and bit counter, and enables the sampler and
//  deserializer at the right times. Checks start, parity and stop, then
//  pulses data_valid once per good frame.
//  Sits between the raw rx line and the sampler/deserializer/checker datapath.
// PARAMETERS
//  PRESCALER  16  oversampling ticks per bit; legal 8, 16, 32 (edge_cnt is 5 b)
//  DATA_W     8   data bits per frame; legal 5..8
// PORTS
//  clk2          in   1  oversampling clock (PRESCALER ticks per bit)
//  rst           in   1  asynchronous, active-high reset
//  rx_in         in   1  raw serial line, idle high
//  sampled_data  in   1  sampler output bit; valid when edge_cnt==PRESCALER-1
//  par_en        in   1  1 = frame carries a parity bit
//  par_typ       in   1  0 = even parity, 1 = odd parity
//  edge_cnt      out  5  tick index inside current bit, 0..PRESCALER-1
//  bit_cnt       out  4  0 = start, 1..DATA_W = data, then parity, then stop
//  samp_en       out  1  sampler enable; high in every non-IDLE, non-CHECK state
//  des_en        out  1  deserializer shift enable; high only in DATA
//  data_valid    out  1  one-cycle pulse; frame good, parallel data usable
//  par_err       out  1  parity mismatch on last frame (sticky)
//  stp_err       out  1  stop bit sampled low on last frame (sticky)
//  busy          out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE. All outputs 0. Internal parity acc=0.
//    Asserting rst mid-frame aborts the frame, with no data_valid.
//  States: IDLE, START, DATA, PARITY, STOP, CHECK (binary encoded).
//  Counting (non-IDLE, non-CHECK states):
//    - edge_cnt increments each clk2 cycle.
//    - At PRESCALER-1, edge_cnt wraps to 0 and bit_cnt increments.
//    - In IDLE and CHECK, both counters are held at 0.
//  "bit end" = the cycle with edge_cnt==PRESCALER-1. All decisions happen there.
//  IDLE -> START when rx_in==0. That cycle latches par_en/par_typ and clears
//    par_err, stp_err and acc. Config changes mid-frame are ignored.
//  START at bit end:
//    - sampled_data==1 (glitch): -> IDLE, no flags set.
//    - otherwise -> DATA, bit_cnt=1.
//  DATA at bit end:
//    - acc ^= sampled_data.
//    - bit_cnt==DATA_W: -> PARITY if latched par_en, else -> STOP.
//  PARITY at bit end: par_err <= (sampled_data != acc^par_typ); -> STOP.
//  STOP at bit end: stp_err <= ~sampled_data; -> CHECK.
//  CHECK (exactly 1 cycle):
//    - data_valid = ~par_err & ~stp_err.
//    - -> IDLE unconditionally.
//    - rx_in low during CHECK is first seen in IDLE on the next cycle. Adds
//      1 tick of slip; tolerated by the centre sampling.
//  data_valid: registered, high for exactly one clk2 cycle, never on a glitch.
//  Latency: the data_valid cycle falls 1 + PRESCALER*(DATA_W+2+par_en) cycles
//    after the IDLE cycle that sees rx_in==0.
//  des_en is combinational from state (DATA). The deserializer shifts on
//    des_en & bit end, giving exactly DATA_W shifts per frame.
//  par_err/stp_err hold until the next START entry.
//  Break (rx_in held low): stp_err=1, no data_valid. The FSM then re-enters
//    START, and every frame after that fails at STOP until the line goes high.
// STRUCTURE
//  uart_rx_pkg:
//    - state localparams ST_IDLE..ST_CHECK
//    - BIT_START=0
//    - PAR_EVEN=0, PAR_ODD=1
//    - EDGE_W=5, BIT_W=4
//  Sub-module uart_rx_edge_bit_cnt: edge_cnt/bit_cnt with enable and
//    synchronous clear. Everything else (FSM, parity acc, flags) lives in
//    uart_rx_fsm.
// TESTING (PRESCALER=16, DATA_W=8; sampler model drives sampled_data from rx_in)
//  1 No parity, byte 0xA5, stop=1
//    -> data_valid pulse 161 cycles after the start edge.
//    -> par_err=0, stp_err=0. des_en high for exactly 128 cycles.
//  2 par_en=1, par_typ=0, 0x0F, parity bit 0
//    -> data_valid=1, par_err=0.
//    Repeat with parity bit 1 -> par_err=1, data_valid never asserts.
//  3 par_en=1, par_typ=1, 0x01, parity bit 0 -> data_valid=1.
//    Then stop=0 -> stp_err=1, no data_valid.
//  4 rx_in low for 6 ticks, then high
//    -> START->IDLE at edge_cnt=15. No flags, no data_valid, busy low after.
//  5 rst pulsed while bit_cnt=4 in DATA
//    -> all outputs 0 immediately.
//    -> next clean frame 0x3C -> data_valid=1.
//  6 Two back-to-back frames 0x55, 0xAA with no idle gap
//    -> two data_valid pulses, 161 cycles apart ±1, no errors.
//    par_en toggled mid-frame -> ignored until the next START.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int EDGE_W = 5;
    localparam int BIT_W  = 4;

    // bit_cnt value while the start bit is being received
    localparam logic [BIT_W-1:0] BIT_START = '0;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_CHECK  = 3'd5
    } state_t;

    // Parity bit the transmitter should have sent, given the XOR of the data bits
    function automatic logic exp_parity(input logic acc, input logic typ);
        logic p;
        p = acc;
        case (typ)
            PAR_EVEN: p = acc;
            PAR_ODD:  p = ~acc;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_edge_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_edge_bit_cnt
// Description : Oversampling tick counter and bit counter for the UART
//               receiver. edge_cnt wraps at PRESCALER-1 and advances bit_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESCALER = 16
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              bit_end
);

    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(PRESCALER - 1);

    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;

    // Next-count logic: clear dominates, otherwise count while enabled
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clr) begin
            edge_cnt_d = '0;
            bit_cnt_d  = BIT_START;
        end else if (en) begin
            if (edge_cnt_q == EDGE_LAST) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= BIT_START;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;
    assign bit_end  = (edge_cnt_q == EDGE_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm
// Description : UART receive frame sequencer. Detects the start bit, drives
//               the sampler/deserializer enables, checks start/parity/stop
//               and pulses data_valid once per good frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int PRESCALER = 16,
    parameter int DATA_W    = 8
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              sampled_data,
    input  logic              par_en,
    input  logic              par_typ,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              samp_en,
    output logic              des_en,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);

    localparam logic [BIT_W-1:0] BIT_LAST_DATA = BIT_W'(DATA_W);

    state_t state_q, state_d;
    logic   par_en_q,     par_en_d;
    logic   par_typ_q,    par_typ_d;
    logic   acc_q,        acc_d;
    logic   par_err_q,    par_err_d;
    logic   stp_err_q,    stp_err_d;
    logic   data_valid_q, data_valid_d;

    logic   cnt_en;
    logic   cnt_clr;
    logic   bit_end;

    uart_rx_edge_bit_cnt #(
        .PRESCALER (PRESCALER)
    ) u_cnt (
        .clk2     (clk2),
        .rst      (rst),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    // Next state, parity accumulation and error flags; decisions only at bit end
    always_comb begin
        state_d      = state_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        acc_d        = acc_q;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        data_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_in) begin
                    state_d   = ST_START;
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                    acc_d     = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = sampled_data ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    acc_d = acc_q ^ sampled_data;
                    if (bit_cnt == BIT_LAST_DATA) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    par_err_d = (sampled_data != exp_parity(acc_q, par_typ_q));
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    stp_err_d = ~sampled_data;
                    // Registered here so the pulse lands in the CHECK cycle,
                    // equal to ~par_err & ~stp_err as seen during CHECK
                    data_valid_d = sampled_data & ~par_err_q;
                    state_d      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counters run only inside a frame and are cleared on the way to IDLE/CHECK
    always_comb begin
        cnt_en  = (state_q != ST_IDLE) && (state_q != ST_CHECK);
        cnt_clr = !cnt_en || (state_d == ST_IDLE) || (state_d == ST_CHECK);
    end

    // State and flag registers
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            acc_q        <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            acc_q        <= acc_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign samp_en    = cnt_en;
    assign des_en     = (state_q == ST_DATA);
    assign busy       = (state_q != ST_IDLE);
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fsm
// Description : Self-checking bench for uart_rx_fsm with a centre-sampling
//               sampler model, a deserializer model and a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_fsm;

    localparam int PRESCALER = 16;
    localparam int DATA_W    = 8;

    logic       clk2 = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       sampled_data;
    logic       par_en;
    logic       par_typ;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       samp_en;
    logic       des_en;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    uart_rx_fsm #(
        .PRESCALER (PRESCALER),
        .DATA_W    (DATA_W)
    ) dut (
        .clk2         (clk2),
        .rst          (rst),
        .rx_in        (rx_in),
        .sampled_data (sampled_data),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .samp_en      (samp_en),
        .des_en       (des_en),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .busy         (busy)
    );

    always #5 clk2 = ~clk2;

    // Free-running cycle count, used to time the data_valid pulse
    int cyc = 0;
    always @(posedge clk2) cyc <= cyc + 1;

    // Sampler model: capture the line at bit centre, present it at bit end
    logic       samp_q = 1'b1;
    logic [7:0] des_q  = 8'h00;
    always @(posedge clk2 or posedge rst) begin
        if (rst) begin
            samp_q <= 1'b1;
            des_q  <= 8'h00;
        end else begin
            if (samp_en && edge_cnt == 5'(PRESCALER / 2 - 1)) samp_q <= rx_in;
            if (des_en && edge_cnt == 5'(PRESCALER - 1)) des_q <= {samp_q, des_q[7:1]};
        end
    end
    assign sampled_data = samp_q;

    // Scoreboard
    typedef struct {
        logic [7:0] data;
        int         t_start;
        int         lat;
        int         slip;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk2);
            #1;
        end
    endtask

    // Output monitor: count pulses and DATA cycles, pop and compare on data_valid
    int dv_count   = 0;
    int des_cycles = 0;
    int dv_cyc[$];
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk2);
            if (des_en) des_cycles++;
            if (data_valid) begin
                dv_count++;
                dv_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check("dv_unexpected", 32'd1, 32'd0);
                end else begin
                    e   = sb_q.pop_front();
                    lat = cyc - e.t_start;
                    check("dv_data", {24'h0, des_q}, {24'h0, e.data});
                    check($sformatf("dv_latency_%0d", lat),
                          {31'b0, (lat >= e.lat) && (lat <= e.lat + e.slip)}, 32'd1);
                end
            end
        end
    end

    logic exp_par_err;
    logic exp_stp_err;

    // Serialize one frame LSB first; push an expectation only for a good frame
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic par_flip, input logic stop_bit,
                              input logic toggle_cfg, input int slip);
        exp_t e;
        par_en      = pe;
        par_typ     = pt;
        rx_in       = 1'b0;
        e.data      = d;
        e.t_start   = cyc;
        e.lat       = 1 + PRESCALER * (DATA_W + 2 + int'(pe));
        e.slip      = slip;
        exp_par_err = pe & par_flip;
        exp_stp_err = ~stop_bit;
        if (!exp_par_err && !exp_stp_err) sb_q.push_back(e);
        tick(PRESCALER);
        for (int i = 0; i < DATA_W; i++) begin
            rx_in = d[i];
            if (toggle_cfg && i == 3) begin
                par_en  = ~pe;
                par_typ = ~pt;
            end
            tick(PRESCALER);
        end
        if (pe) begin
            rx_in = (^d) ^ pt ^ par_flip;
            tick(PRESCALER);
        end
        rx_in = stop_bit;
        tick(PRESCALER);
        rx_in = 1'b1;
    endtask

    function automatic logic [14:0] all_outs();
        return {edge_cnt, bit_cnt, samp_en, des_en, data_valid, par_err, stp_err, busy};
    endfunction

    initial begin
        int   dv0;
        int   n;
        logic [4:0] prev_edge;
        logic [3:0] prev_bit;
        logic prev_busy;

        rst     = 1'b1;
        rx_in   = 1'b1;
        par_en  = 1'b0;
        par_typ = 1'b0;
        tick(3);
        check("reset_outputs", {17'h0, all_outs()}, 32'd0);
        rst = 1'b0;
        tick(5);

        // 1: no parity, 0xA5
        des_cycles = 0;
        dv0 = dv_count;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        tick(4);
        check("t1_dv_count", dv_count - dv0, 32'd1);
        check("t1_par_err", {31'b0, par_err}, 32'd0);
        check("t1_stp_err", {31'b0, stp_err}, 32'd0);
        check("t1_des_cycles", des_cycles, 32'd128);
        check("t1_busy", {31'b0, busy}, 32'd0);

        // 2: even parity, 0x0F, correct then wrong parity bit
        dv0 = dv_count;
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        tick(4);
        check("t2a_dv_count", dv_count - dv0, 32'd1);
        check("t2a_par_err", {31'b0, par_err}, {31'b0, exp_par_err});
        dv0 = dv_count;
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        tick(4);
        check("t2b_dv_count", dv_count - dv0, 32'd0);
        check("t2b_par_err", {31'b0, par_err}, 32'd1);
        check("t2b_stp_err", {31'b0, stp_err}, 32'd0);

        // 3: odd parity, 0x01, good frame then bad stop bit
        dv0 = dv_count;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        tick(4);
        check("t3a_dv_count", dv_count - dv0, 32'd1);
        check("t3a_par_err", {31'b0, par_err}, 32'd0);
        dv0 = dv_count;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick(4);
        check("t3b_dv_count", dv_count - dv0, 32'd0);
        check("t3b_stp_err", {31'b0, stp_err}, 32'd1);
        check("t3b_par_err", {31'b0, par_err}, 32'd0);

        // 4: 6-tick glitch on the line
        dv0       = dv_count;
        par_en    = 1'b0;
        rx_in     = 1'b0;
        tick(6);
        rx_in     = 1'b1;
        prev_edge = '0;
        prev_bit  = '0;
        for (int i = 0; i < 40; i++) begin
            prev_edge = edge_cnt;
            prev_bit  = bit_cnt;
            prev_busy = busy;
            tick(1);
            if (prev_busy && !busy) break;
        end
        check("t4_abort_edge", {27'h0, prev_edge}, 32'd15);
        check("t4_abort_bit", {28'h0, prev_bit}, 32'd0);
        tick(4);
        check("t4_busy", {31'b0, busy}, 32'd0);
        check("t4_flags", {30'b0, par_err, stp_err}, 32'd0);
        check("t4_dv_count", dv_count - dv0, 32'd0);

        // 5: reset in the middle of the data bits, then a clean frame
        dv0   = dv_count;
        rx_in = 1'b0;
        tick(PRESCALER);
        rx_in = 1'b1;
        n = 0;
        while (!(des_en && bit_cnt == 4'd4) && n < 200) begin
            tick(1);
            n++;
        end
        check("t5_reach_bit4", {28'h0, bit_cnt}, 32'd4);
        rst = 1'b1;
        #1;
        check("t5_reset_outputs", {17'h0, all_outs()}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("t5_no_dv", dv_count - dv0, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        tick(4);
        check("t5_dv_count", dv_count - dv0, 32'd1);

        // 6: back-to-back frames, config toggled mid-frame on the first
        dv0 = dv_count;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        tick(10);
        check("t6_dv_count", dv_count - dv0, 32'd2);
        check("t6_flags", {30'b0, par_err, stp_err}, 32'd0);
        if (dv_cyc.size() >= 2) begin
            n = dv_cyc[dv_cyc.size()-1] - dv_cyc[dv_cyc.size()-2];
            check($sformatf("t6_dv_spacing_%0d", n), {31'b0, (n >= 160) && (n <= 162)}, 32'd1);
        end else begin
            check("t6_dv_spacing_missing", dv_cyc.size(), 32'd2);
        end

        tick(20);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
